// File: rtl/mem_wb_multi_lane_pipe.sv
// mem_wb_multi_lane_pipe: NUM_LANES-wide MEM/WB pipeline register with stall, flush,
// x0 write suppression, same-bundle WAW resolution and a saturating retire counter.
//   clk, reset (async active-low)   clock and reset
//   stall / flush / cnt_clear       hold, bubble, retire counter clear
//   *_mem                           per-lane MEM-side valid, write enable, dest, data
//   *_wb                            registered WB-side lane state
//   retire_count                    saturating count of retired lanes
module mem_wb_multi_lane_pipe #(
    parameter int NUM_LANES         = 2,
    parameter int DATA_W            = 32,
    parameter int REG_ADDR_W        = 5,
    parameter int CNT_W             = 16,
    parameter bit ZERO_REG_SUPPRESS = 1
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             stall,
    input  logic                             flush,
    input  logic                             cnt_clear,
    input  logic [NUM_LANES-1:0]             valid_mem,
    input  logic [NUM_LANES-1:0]             reg_write_en_mem,
    input  logic [NUM_LANES*REG_ADDR_W-1:0]  dest_reg_mem,
    input  logic [NUM_LANES*DATA_W-1:0]      write_data_mem,
    output logic [NUM_LANES-1:0]             valid_wb,
    output logic [NUM_LANES-1:0]             reg_write_en_wb,
    output logic [NUM_LANES*REG_ADDR_W-1:0]  dest_reg_wb,
    output logic [NUM_LANES*DATA_W-1:0]      write_data_wb,
    output logic [CNT_W-1:0]                 retire_count
);
    logic [NUM_LANES-1:0] we_q;
    logic [NUM_LANES-1:0] we_m;
    // three guard bits so up to four lanes added to a full counter cannot wrap
    logic [CNT_W+2:0]     cnt_sum;
    always_comb begin
        we_q = reg_write_en_mem & valid_mem;
        for (int k = 0; k < NUM_LANES; k++)
            if (ZERO_REG_SUPPRESS && dest_reg_mem[k*REG_ADDR_W +: REG_ADDR_W] == '0) we_q[k] = 1'b0;
        // an older lane loses its enable when a younger lane writes the same register
        we_m = we_q;
        for (int k = 0; k < NUM_LANES; k++)
            for (int j = k + 1; j < NUM_LANES; j++)
                if (we_q[j] && dest_reg_mem[j*REG_ADDR_W +: REG_ADDR_W] == dest_reg_mem[k*REG_ADDR_W +: REG_ADDR_W])
                    we_m[k] = 1'b0;
        cnt_sum = {3'b000, retire_count};
        for (int k = 0; k < NUM_LANES; k++)
            cnt_sum = cnt_sum + (CNT_W+3)'(valid_mem[k]);
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_wb        <= '0;
            reg_write_en_wb <= '0;
            dest_reg_wb     <= '0;
            write_data_wb   <= '0;
            retire_count    <= '0;
        end else begin
            if (flush) begin
                valid_wb        <= '0;
                reg_write_en_wb <= '0;
                dest_reg_wb     <= '0;
                write_data_wb   <= '0;
            end else if (!stall) begin
                valid_wb        <= valid_mem;
                reg_write_en_wb <= we_m;
                dest_reg_wb     <= dest_reg_mem;
                write_data_wb   <= write_data_mem;
            end
            if (cnt_clear)
                retire_count <= '0;
            else if (!flush && !stall)
                retire_count <= (|cnt_sum[CNT_W+2:CNT_W]) ? '1 : cnt_sum[CNT_W-1:0];
        end
    end
endmodule

// File: tb/tb_mem_wb_multi_lane_pipe.sv
// tb_mem_wb_multi_lane_pipe: directed scoreboard bench for the two-lane MEM/WB register
module tb_mem_wb_multi_lane_pipe;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        cnt_clear = 1'b0;
    logic [1:0]  valid_mem = '0;
    logic [1:0]  reg_write_en_mem = '0;
    logic [9:0]  dest_reg_mem = '0;
    logic [63:0] write_data_mem = '0;
    logic [1:0]  valid_wb;
    logic [1:0]  reg_write_en_wb;
    logic [9:0]  dest_reg_wb;
    logic [63:0] write_data_wb;
    logic [3:0]  retire_count;

    typedef struct {
        logic [1:0]  v;
        logic [1:0]  we;
        logic [4:0]  d0;
        logic [4:0]  d1;
        logic [31:0] x0;
        logic [31:0] x1;
        logic [3:0]  cnt;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass = 0;

    mem_wb_multi_lane_pipe #(
        .NUM_LANES(2), .DATA_W(32), .REG_ADDR_W(5), .CNT_W(4), .ZERO_REG_SUPPRESS(1)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .cnt_clear(cnt_clear),
        .valid_mem(valid_mem), .reg_write_en_mem(reg_write_en_mem),
        .dest_reg_mem(dest_reg_mem), .write_data_mem(write_data_mem),
        .valid_wb(valid_wb), .reg_write_en_wb(reg_write_en_wb),
        .dest_reg_wb(dest_reg_wb), .write_data_wb(write_data_wb),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    // monitor: one expected entry per capturing edge, compared just after that edge
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check("valid_wb", 64'(valid_wb), 64'(e.v));
            check("reg_write_en_wb", 64'(reg_write_en_wb), 64'(e.we));
            check("dest_wb0", 64'(dest_reg_wb[4:0]), 64'(e.d0));
            check("dest_wb1", 64'(dest_reg_wb[9:5]), 64'(e.d1));
            check("data_wb0", 64'(write_data_wb[31:0]), 64'(e.x0));
            check("data_wb1", 64'(write_data_wb[63:32]), 64'(e.x1));
            check("retire_count", 64'(retire_count), 64'(e.cnt));
        end
    end

    task automatic step(input logic [1:0] v, we, input logic [4:0] d0, d1, input logic [31:0] x0, x1,
                        input logic st, fl, clr,
                        input logic [1:0] ev, ewe, input logic [4:0] ed0, ed1,
                        input logic [31:0] ex0, ex1, input logic [3:0] ecnt);
        exp_t e;
        @(negedge clk);
        valid_mem = v; reg_write_en_mem = we;
        dest_reg_mem = {d1, d0}; write_data_mem = {x1, x0};
        stall = st; flush = fl; cnt_clear = clr;
        e.v = ev; e.we = ewe; e.d0 = ed0; e.d1 = ed1; e.x0 = ex0; e.x1 = ex1; e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        #12;
        check("reset valid_wb", 64'(valid_wb), 64'd0);
        check("reset we_wb", 64'(reg_write_en_wb), 64'd0);
        check("reset data_wb", write_data_wb, 64'd0);
        check("reset retire_count", 64'(retire_count), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        // basic two-lane load
        step(2'b11, 2'b11, 5'd5, 5'd7, 32'hDEADBEEF, 32'h12345678, 0, 0, 0,
             2'b11, 2'b11, 5'd5, 5'd7, 32'hDEADBEEF, 32'h12345678, 4'd2);
        // same-bundle WAW: youngest lane keeps its enable
        step(2'b11, 2'b11, 5'd9, 5'd9, 32'h11, 32'h22, 0, 0, 0,
             2'b11, 2'b10, 5'd9, 5'd9, 32'h11, 32'h22, 4'd4);
        // x0 on lane 0 only
        step(2'b11, 2'b11, 5'd0, 5'd3, 32'h33, 32'h44, 0, 0, 0,
             2'b11, 2'b10, 5'd0, 5'd3, 32'h33, 32'h44, 4'd6);
        // x0 on both lanes
        step(2'b11, 2'b11, 5'd0, 5'd0, 32'h55, 32'h66, 0, 0, 0,
             2'b11, 2'b00, 5'd0, 5'd0, 32'h55, 32'h66, 4'd8);
        // invalid younger lane must not mask the older writer
        step(2'b01, 2'b11, 5'd4, 5'd4, 32'h77, 32'h88, 0, 0, 0,
             2'b01, 2'b01, 5'd4, 5'd4, 32'h77, 32'h88, 4'd9);
        // stall three cycles with changing inputs
        step(2'b11, 2'b11, 5'd1, 5'd2, 32'hAA, 32'hBB, 1, 0, 0,
             2'b01, 2'b01, 5'd4, 5'd4, 32'h77, 32'h88, 4'd9);
        step(2'b10, 2'b10, 5'd6, 5'd8, 32'hCC, 32'hDD, 1, 0, 0,
             2'b01, 2'b01, 5'd4, 5'd4, 32'h77, 32'h88, 4'd9);
        step(2'b11, 2'b01, 5'd10, 5'd11, 32'hEE, 32'hFF, 1, 0, 0,
             2'b01, 2'b01, 5'd4, 5'd4, 32'h77, 32'h88, 4'd9);
        // flush during stall still flushes, counter unchanged
        step(2'b11, 2'b11, 5'd12, 5'd13, 32'h1234, 32'h5678, 1, 1, 0,
             2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'd9);
        // clear together with flush
        step(2'b11, 2'b11, 5'd12, 5'd13, 32'h1234, 32'h5678, 0, 1, 1,
             2'b00, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0, 4'd0);
        // nine bundles of two lanes: 2,4,...,14,15,15
        for (int i = 0; i < 9; i++)
            step(2'b11, 2'b11, 5'(i + 1), 5'(i + 20), 32'(i * 32'h101), 32'(~i), 0, 0, 0,
                 2'b11, 2'b11, 5'(i + 1), 5'(i + 20), 32'(i * 32'h101), 32'(~i),
                 4'((2 * (i + 1) > 15) ? 15 : 2 * (i + 1)));
        // clear wins over stall hold
        step(2'b11, 2'b11, 5'd30, 5'd31, 32'h9, 32'h9, 1, 0, 1,
             2'b11, 2'b11, 5'd9, 5'd28, 32'h808, ~32'd8, 4'd0);
        // clear wins over increment
        step(2'b11, 2'b11, 5'd30, 5'd31, 32'hA1, 32'hA2, 0, 0, 1,
             2'b11, 2'b11, 5'd30, 5'd31, 32'hA1, 32'hA2, 4'd0);
        step(2'b10, 2'b10, 5'd14, 5'd15, 32'hB1, 32'hB2, 0, 0, 0,
             2'b10, 2'b10, 5'd14, 5'd15, 32'hB1, 32'hB2, 4'd1);
        @(negedge clk);
        stall = 1'b1; flush = 1'b0; cnt_clear = 1'b0;
        @(posedge clk);
        #3;
        // asynchronous reset between edges
        reset = 1'b0;
        #1;
        check("async reset valid_wb", 64'(valid_wb), 64'd0);
        check("async reset we_wb", 64'(reg_write_en_wb), 64'd0);
        check("async reset dest_wb", 64'(dest_reg_wb), 64'd0);
        check("async reset data_wb", write_data_wb, 64'd0);
        check("async reset retire_count", 64'(retire_count), 64'd0);
        check("scoreboard drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
